// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_ctrl_pkg;

  localparam int UART_WORD_W = 9;

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request after rr_ptr, wrapping modulo NUM_REQ.
module rr_picker #(
  parameter int  NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     rr_ptr,
  output logic [IDW-1:0]     winner,
  output logic               any_req
);

  logic [IDW-1:0] idx;

  // Scan farthest-first so the nearest set bit after rr_ptr overwrites and wins.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int i = NUM_REQ; i >= 1; i--) begin
      idx = IDW'((int'(rr_ptr) + i) % NUM_REQ);
      if (req[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ requesters,
// with start strobe, busy/ready tracking and a sticky busy-timeout flag.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int  NUM_REQ      = 4,
  parameter int  BUSY_TIMEOUT = 16,
  localparam int IDW          = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*UART_WORD_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             req_accept,
  output logic [NUM_REQ-1:0]             req_done,
  output logic                           uart_start,
  output logic [UART_WORD_W-1:0]         uart_data,
  input  logic                           uart_ready,
  input  logic                           uart_busy,
  output logic [IDW-1:0]                 grant_id,
  output logic                           arb_busy,
  output logic                           timeout_err,
  input  logic                           err_clr
);

  localparam int CW = $clog2(BUSY_TIMEOUT + 1);

  arb_state_t             state_q, state_d;
  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]         grant_id_q, grant_id_d;
  logic [UART_WORD_W-1:0] uart_data_q, uart_data_d;
  logic [NUM_REQ-1:0]     req_accept_q, req_accept_d;
  logic [NUM_REQ-1:0]     req_done_q, req_done_d;
  logic                   uart_start_q, uart_start_d;
  logic                   timeout_err_q, timeout_err_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  logic [IDW-1:0]         winner;
  logic                   any_req;

  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req     (req_valid),
    .rr_ptr  (rr_ptr_q),
    .winner  (winner),
    .any_req (any_req)
  );

  // Outputs are registered, so each pulse appears the cycle after its decision.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_id_d    = grant_id_q;
    uart_data_d   = uart_data_q;
    req_accept_d  = '0;
    req_done_d    = '0;
    uart_start_d  = 1'b0;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err_q & ~err_clr;

    case (state_q)
      ARB: begin
        if (any_req) begin
          uart_data_d          = req_data[int'(winner)*UART_WORD_W +: UART_WORD_W];
          grant_id_d           = winner;
          rr_ptr_d             = winner;
          req_accept_d[winner] = 1'b1;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        if (uart_ready) begin
          uart_start_d = 1'b1;
          cnt_d        = '0;
          state_d      = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (uart_busy) begin
          state_d = WAIT_DONE;
        end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
          // The word is dropped; the requester still gets its done pulse.
          timeout_err_d          = 1'b1;
          req_done_d[grant_id_q] = 1'b1;
          state_d                = ARB;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_DONE: begin
        if (uart_ready && !uart_busy) begin
          req_done_d[grant_id_q] = 1'b1;
          state_d                = ARB;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB;
      rr_ptr_q      <= IDW'(NUM_REQ - 1);
      grant_id_q    <= '0;
      uart_data_q   <= '0;
      req_accept_q  <= '0;
      req_done_q    <= '0;
      uart_start_q  <= 1'b0;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_id_q    <= grant_id_d;
      uart_data_q   <= uart_data_d;
      req_accept_q  <= req_accept_d;
      req_done_q    <= req_done_d;
      uart_start_q  <= uart_start_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign req_accept  = req_accept_q;
  assign req_done    = req_done_q;
  assign uart_start  = uart_start_q;
  assign uart_data   = uart_data_q;
  assign grant_id    = grant_id_q;
  assign timeout_err = timeout_err_q;
  assign arb_busy    = (state_q != ARB);

endmodule
